// File: rtl/sum_bcd_display.sv
// sum_bcd_display: captures the 5-bit ripple-carry adder result on a rising
// LOAD edge, converts it to two BCD digits with a shift-add-3 (double-dabble)
// sequence, and drives two active-low seven-segment displays.
//
// Build option: define LEADING_ZERO_BLANK_EN to blank the tens display (HEX1)
// whenever the tens digit is zero, including the reset value. With the macro
// undefined, HEX1 always shows the tens digit.
//
// Timing: capture at edge E0, conversion steps at E1..E5, and new BCD/HEX
// values with a one-cycle VALID pulse at E5. BUSY is high for exactly five
// cycles. LOAD edges seen while converting are dropped, not queued.

module sum_bcd_display (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       LOAD,
  input  logic [4:0] SUM,
  output logic       BUSY,
  output logic       VALID,
  output logic [7:0] BCD,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_e;

  // Active-low segment patterns, bit6=g ... bit0=a.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // The last conversion step is taken when the counter holds 4 (steps 1..5
  // run with counter values 0..4).
  localparam logic [2:0] LAST_STEP = 3'd4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HEX1_RESET = SEG_BLANK;
`else
  localparam logic [6:0] HEX1_RESET = SEG_ZERO;
`endif

  // Decimal digit to active-low segments. Codes above 9 never occur here and
  // show as blank.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Tens display, with optional leading-zero blanking.
  function automatic logic [6:0] tens_seg(input logic [3:0] tens);
`ifdef LEADING_ZERO_BLANK_EN
    return (tens == 4'd0) ? SEG_BLANK : seg7(tens);
`else
    return seg7(tens);
`endif
  endfunction

  // Double-dabble correction: a nibble of 5 or more gets 3 added so that the
  // following shift carries correctly into the next decimal digit.
  function automatic logic [3:0] add3(input logic [3:0] nibble);
    return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
  endfunction

  state_e      state_q, state_d;
  logic        load_q;
  logic [4:0]  shift_q, shift_d;
  logic [7:0]  scratch_q, scratch_d;
  logic [2:0]  step_q, step_d;
  logic [7:0]  bcd_q, bcd_d;
  logic [6:0]  hex1_q, hex1_d;
  logic [6:0]  hex0_q, hex0_d;
  logic        valid_q, valid_d;

  logic        load_rise;
  logic [12:0] dabble_in;
  logic [12:0] dabble_out;
  logic [7:0]  scratch_next;
  logic [4:0]  shift_next;

  // A rising edge is LOAD high now while it was low on the previous clock.
  assign load_rise = LOAD & ~load_q;

  // One conversion step: correct both scratch nibbles, then shift the joined
  // {scratch, shift} register left by one. The tens nibble never exceeds 3
  // for inputs up to 31, so the bit shifted out of the top is always zero.
  assign dabble_in    = {add3(scratch_q[7:4]), add3(scratch_q[3:0]), shift_q};
  assign dabble_out   = dabble_in << 1;
  assign scratch_next = dabble_out[12:5];
  assign shift_next   = dabble_out[4:0];

  // Registers: FSM state, LOAD history, conversion datapath and outputs.
  // NOTE: every register here uses non-blocking assignments so all of them
  // update from the same pre-edge values; blocking assignments would make
  // the result depend on statement order.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      load_q    <= 1'b0;
      shift_q   <= '0;
      scratch_q <= '0;
      step_q    <= '0;
      bcd_q     <= '0;
      hex1_q    <= HEX1_RESET;
      hex0_q    <= SEG_ZERO;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_q    <= LOAD;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      step_q    <= step_d;
      bcd_q     <= bcd_d;
      hex1_q    <= hex1_d;
      hex0_q    <= hex0_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state and datapath control for the IDLE/CONV sequencer.
  // NOTE: every signal driven here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    step_d    = step_q;
    bcd_d     = bcd_q;
    hex1_d    = hex1_q;
    hex0_d    = hex0_q;
    valid_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (load_rise) begin
          shift_d   = SUM;
          scratch_d = '0;
          step_d    = '0;
          state_d   = S_CONV;
        end
      end

      S_CONV: begin
        // LOAD edges are deliberately ignored here; load_q keeps tracking
        // LOAD, so such an edge is lost rather than queued.
        scratch_d = scratch_next;
        shift_d   = shift_next;
        step_d    = step_q + 3'd1;
        if (step_q == LAST_STEP) begin
          bcd_d   = scratch_next;
          hex1_d  = tens_seg(scratch_next[7:4]);
          hex0_d  = seg7(scratch_next[3:0]);
          valid_d = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign BUSY  = (state_q == S_CONV);
  assign VALID = valid_q;
  assign BCD   = bcd_q;
  assign HEX1  = hex1_q;
  assign HEX0  = hex0_q;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Self-checking bench for sum_bcd_display. Expected BCD/HEX values are pushed
// to a scoreboard when a conversion is requested and popped when VALID pulses.
// Build with or without LEADING_ZERO_BLANK_EN to match the design build.

module tb_sum_bcd_display;

  typedef struct {
    logic [7:0] bcd;
    logic [6:0] hex1;
    logic [6:0] hex0;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [4:0] sum;
  logic       busy;
  logic       valid;
  logic [7:0] bcd;
  logic [6:0] hex1;
  logic [6:0] hex0;

  int   errors = 0;
  int   checks = 0;
  int   valid_count = 0;
  exp_t sb[$];

  sum_bcd_display dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .LOAD     (load),
    .SUM      (sum),
    .BUSY     (busy),
    .VALID    (valid),
    .BCD      (bcd),
    .HEX1     (hex1),
    .HEX0     (hex0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Segment table written out from the display encoding.
  function automatic logic [6:0] exp_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_tens_seg(input int t);
`ifdef LEADING_ZERO_BLANK_EN
    if (t == 0) return 7'b1111111;
`endif
    return exp_seg(t);
  endfunction

  function automatic exp_t model(input int s);
    exp_t e;
    int   tens = s / 10;
    int   ones = s % 10;
    e.bcd  = 8'((tens << 4) | ones);
    e.hex1 = exp_tens_seg(tens);
    e.hex0 = exp_seg(ones);
    return e;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_bcd"}, 32'(bcd), 32'h00);
    check({tag, "_hex0"}, 32'(hex0), 32'b1000000);
`ifdef LEADING_ZERO_BLANK_EN
    check({tag, "_hex1"}, 32'(hex1), 32'b1111111);
`else
    check({tag, "_hex1"}, 32'(hex1), 32'b1000000);
`endif
  endtask

  // Scoreboard consumer: every VALID pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (valid) begin
      valid_count++;
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_bcd", 32'(bcd), 32'(e.bcd));
        check("sb_hex1", 32'(hex1), 32'(e.hex1));
        check("sb_hex0", 32'(hex0), 32'(e.hex0));
      end
    end
  end

  // One-cycle LOAD pulse, then measure latency and BUSY length. SUM is
  // scrambled right after capture to show it is sampled only at E0.
  task automatic do_conv(input int s);
    int n_busy = 0;
    int lat    = 0;
    bit seen   = 0;
    @(negedge clk);
    sum  = 5'(s);
    load = 1'b1;
    sb.push_back(model(s));
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) begin
        load = 1'b0;
        sum  = ~5'(s);
      end
      lat++;
      if (valid) seen = 1;
      else if (busy) n_busy++;
    end
    check($sformatf("latency_%0d", s), 32'(lat), 32'd6);
    check($sformatf("busy_len_%0d", s), 32'(n_busy), 32'd5);
    @(negedge clk);
    check($sformatf("valid_width_%0d", s), 32'(valid), 32'd0);
    check($sformatf("busy_done_%0d", s), 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc;
    rst_n = 1'b0;
    load  = 1'b0;
    sum   = '0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed conversions: typical value, maximum, minimum.
    do_conv(19);
    check("bcd_19", 32'(bcd), 32'h19);
    check("hex1_19", 32'(hex1), 32'b1111001);
    check("hex0_19", 32'(hex0), 32'b0010000);
    do_conv(31);
    check("bcd_31", 32'(bcd), 32'h31);
    check("hex1_31", 32'(hex1), 32'b0110000);
    check("hex0_31", 32'(hex0), 32'b1111001);
    do_conv(0);
    check("bcd_0", 32'(bcd), 32'h00);

    // LOAD held high with fresh rising edges at E3 and E5: one conversion.
    vc = valid_count;
    @(negedge clk);
    sum  = 5'd9;
    load = 1'b1;
    sb.push_back(model(9));
    @(negedge clk);               // after E0
    @(negedge clk); load = 1'b0;  // after E1, E2 samples 0
    sum = 5'd0;
    @(negedge clk); load = 1'b1;  // after E2, rising edge at E3
    @(negedge clk); load = 1'b0;  // after E3, E4 samples 0
    @(negedge clk); load = 1'b1;  // after E4, rising edge at E5
    repeat (15) @(negedge clk);
    check("held_single_valid", 32'(valid_count - vc), 32'd1);
    check("held_bcd", 32'(bcd), 32'h09);
    check("held_busy", 32'(busy), 32'd0);
    load = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during a conversion: no VALID, reset values, then recover.
    vc = valid_count;
    @(negedge clk);
    sum  = 5'd25;
    load = 1'b1;
    @(negedge clk); load = 1'b0;  // after E0
    @(negedge clk);               // after E1
    @(negedge clk);               // after E2
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    repeat (8) @(negedge clk);
    check_reset_values("abort_hold");
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_valid", 32'(valid_count - vc), 32'd0);
    do_conv(7);
    check("bcd_7", 32'(bcd), 32'h07);
    check("hex0_7", 32'(hex0), 32'b1111000);
`ifdef LEADING_ZERO_BLANK_EN
    check("hex1_7", 32'(hex1), 32'b1111111);
`else
    check("hex1_7", 32'(hex1), 32'b1000000);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
